idwt_tile_ctrl: RTL and testbench

Sequencer for the 2D IDWT core. It accepts an 8x8 coefficient tile as eight 64-bit rows over a valid/ready stream and holds all eight rows stable on the core's parallel inputs for a minimum settle time. It waits for the core's valid, captures the eight reconstructed rows, then streams them out row by row with a last flag. It sits between the coefficient buffer/decoder and the pixel writer.

---
 rtl/idwt_pkg.sv | 20 ++
 rtl/idwt_row_buf.sv | 54 +++++
 rtl/idwt_tile_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_idwt_tile_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idwt_pkg.sv
// Shared constants and types for the 2D IDWT tile sequencer.
//   ROW_W     : bits per row (8 pixels x 8 bits)
//   ROWS      : rows per tile (fixed by the core)
//   TILE_W    : width of the flattened tile bus
//   ROW_IDX_W : width of a row index
//   state_t   : sequencer states
package idwt_pkg;

    localparam int unsigned ROW_W     = 64;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned TILE_W    = ROWS * ROW_W;
    localparam int unsigned ROW_IDX_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/idwt_row_buf.sv
// N-entry x W-bit register file used as the tile input and output buffers.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (clears all rows)
//   wr_en/wr_idx/wr_data : single-row indexed write
//   load_en/load_data : whole-buffer parallel load (wins over wr_en)
//   rd_idx/rd_data    : indexed combinational read
//   flat              : all rows, row i on bits [i*W +: W]
module idwt_row_buf
    import idwt_pkg::*;
#(
    parameter int unsigned W     = ROW_W,
    parameter int unsigned N     = ROWS,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    input  logic             load_en,
    input  logic [N*W-1:0]   load_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data,
    output logic [N*W-1:0]   flat
);

    logic [W-1:0] mem [N];

    // Row storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= load_data[i*W +: W];
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    // Flat view of all rows
    always_comb begin
        flat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            flat[i*W +: W] = mem[i];
        end
    end

endmodule

// File: rtl/idwt_tile_ctrl.sv
// Sequencer for the 2D IDWT core: collects eight input rows, holds them on the
// core inputs, captures the core result and streams it out row by row.
// Optional feature macro: IDWT_TILE_CTRL_STATS_EN adds tile_count/timeout_count.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : input row stream, row 0 first
//   core_in                      : held tile to the core, row r at [r*ROW_W +: ROW_W]
//   core_out/core_valid          : core result and its valid
//   out_valid/out_ready/out_data : output row stream, row 0 first
//   out_last                     : marks row 7
//   tile_count, timeout_count    : statistics (macro only)
//   busy                         : anything but idle LOAD with no rows taken
//   err_timeout                  : sticky forced-capture flag
module idwt_tile_ctrl
    import idwt_pkg::*;
#(
    parameter int unsigned CORE_LAT = 4,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in_data,
    output logic [TILE_W-1:0] core_in,
    input  logic [TILE_W-1:0] core_out,
    input  logic              core_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_data,
    output logic              out_last,
`ifdef IDWT_TILE_CTRL_STATS_EN
    output logic [15:0]       tile_count,
    output logic [7:0]        timeout_count,
`endif
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned HCNT_W = $clog2(TIMEOUT);

    if (TIMEOUT <= CORE_LAT) begin : g_bad_timeout
        $error("TIMEOUT must be greater than CORE_LAT");
    end

    state_t               state, state_n;
    logic [ROW_IDX_W-1:0] rcnt, rcnt_n;
    logic [ROW_IDX_W-1:0] ocnt, ocnt_n;
    logic [HCNT_W-1:0]    hcnt, hcnt_n;
    logic [ROW_W-1:0]     out_data_n;
    logic                 in_wr;
    logic                 capture;
    logic                 forced;
    logic                 tile_done;

    logic [ROW_IDX_W-1:0] ob_rd_idx;
    logic [ROW_W-1:0]     ob_rd_data;
    logic [ROW_W-1:0]     ib_rd_unused;
    logic [TILE_W-1:0]    ob_flat_unused;

    // Input buffer: indexed writes from the stream, flat view feeds the core
    idwt_row_buf #(.W(ROW_W), .N(ROWS)) u_in_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_wr),
        .wr_idx    (rcnt),
        .wr_data   (in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    ('0),
        .rd_data   (ib_rd_unused),
        .flat      (core_in)
    );

    // Output buffer: parallel capture of the core result, indexed read out
    idwt_row_buf #(.W(ROW_W), .N(ROWS)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (capture),
        .load_data (core_out),
        .rd_idx    (ob_rd_idx),
        .rd_data   (ob_rd_data),
        .flat      (ob_flat_unused)
    );

    // Prefetch the row that follows the one currently presented
    assign ob_rd_idx = ocnt + ROW_IDX_W'(1);

    // Next-state and datapath control
    always_comb begin
        state_n    = state;
        rcnt_n     = rcnt;
        hcnt_n     = hcnt;
        ocnt_n     = ocnt;
        out_data_n = out_data;
        in_wr      = 1'b0;
        capture    = 1'b0;
        forced     = 1'b0;
        tile_done  = 1'b0;

        unique case (state)
            LOAD: begin
                if (in_valid && in_ready) begin
                    in_wr = 1'b1;
                    if (rcnt == ROW_IDX_W'(ROWS - 1)) begin
                        rcnt_n  = '0;
                        hcnt_n  = '0;
                        state_n = WAIT;
                    end else begin
                        rcnt_n = rcnt + ROW_IDX_W'(1);
                    end
                end
            end
            WAIT: begin
                hcnt_n = hcnt + HCNT_W'(1);
                // core_valid before the settle time belongs to a stale tile
                if (hcnt >= HCNT_W'(CORE_LAT - 1) && core_valid) begin
                    capture = 1'b1;
                end else if (hcnt == HCNT_W'(TIMEOUT - 1)) begin
                    capture = 1'b1;
                    forced  = 1'b1;
                end
                if (capture) begin
                    hcnt_n     = '0;
                    ocnt_n     = '0;
                    state_n    = DRAIN;
                    out_data_n = core_out[ROW_W-1:0];
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    if (ocnt == ROW_IDX_W'(ROWS - 1)) begin
                        ocnt_n    = '0;
                        state_n   = LOAD;
                        tile_done = 1'b1;
                    end else begin
                        ocnt_n     = ocnt + ROW_IDX_W'(1);
                        out_data_n = ob_rd_data;
                    end
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            rcnt        <= '0;
            hcnt        <= '0;
            ocnt        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            rcnt        <= rcnt_n;
            hcnt        <= hcnt_n;
            ocnt        <= ocnt_n;
            in_ready    <= (state_n == LOAD);
            out_valid   <= (state_n == DRAIN);
            out_last    <= (state_n == DRAIN) && (ocnt_n == ROW_IDX_W'(ROWS - 1));
            out_data    <= out_data_n;
            busy        <= !((state_n == LOAD) && (rcnt_n == '0));
            err_timeout <= err_timeout || forced;
        end
    end

`ifdef IDWT_TILE_CTRL_STATS_EN
    // Completed tiles wrap; forced captures saturate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (tile_done) begin
                tile_count <= tile_count + 16'd1;
            end
            if (forced && timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end
`else
    logic tile_done_unused;
    assign tile_done_unused = tile_done;
`endif

endmodule

// File: tb/tb_idwt_tile_ctrl.sv
// Self-checking bench for idwt_tile_ctrl: table of tile scenarios driven with
// random data, gaps and stalls, checked every cycle against a tile-level model.
`timescale 1ns/1ps
module tb_idwt_tile_ctrl;
    import idwt_pkg::*;

    localparam int unsigned CORE_LAT = 4;
    localparam int unsigned TIMEOUT  = 32;

    localparam int CV_ALWAYS = 0;
    localparam int CV_EARLY  = 1;
    localparam int CV_LATE   = 2;
    localparam int CV_NEVER  = 3;

    typedef struct {
        int gap_pct;
        int stall_pct;
        int cv_mode;
        bit seq_data;
        bit b2b;
        int exp_lat;
        bit exp_err;
    } tcase_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  in_data;
    logic [TILE_W-1:0] core_in;
    logic [TILE_W-1:0] core_out;
    logic              core_valid;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              err_timeout;
`ifdef IDWT_TILE_CTRL_STATS_EN
    logic [15:0]       tile_count;
    logic [7:0]        timeout_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit err_m = 1'b0;

    always #5 clk = ~clk;

    idwt_tile_ctrl #(.CORE_LAT(CORE_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .core_in       (core_in),
        .core_out      (core_out),
        .core_valid    (core_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
`ifdef IDWT_TILE_CTRL_STATS_EN
        .tile_count    (tile_count),
        .timeout_count (timeout_count),
`endif
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    // Stand-in for the IDWT core: reverses row order, swaps halves, salts per row
    function automatic logic [TILE_W-1:0] core_fn(input logic [TILE_W-1:0] t);
        logic [TILE_W-1:0] o;
        logic [ROW_W-1:0]  s;
        o = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            s = t[(int'(ROWS) - 1 - r) * int'(ROW_W) +: ROW_W];
            o[r * int'(ROW_W) +: ROW_W] = {s[31:0], s[63:32]} ^ (64'hF0E1_D2C3_B4A5_9687 + 64'(r));
        end
        return o;
    endfunction

    assign core_out = core_fn(core_in);

    // core_valid as a function of the hold count k (k < 0: still loading)
    function automatic bit cv_fn(input int mode, input int k);
        case (mode)
            CV_ALWAYS: return 1'b1;
            CV_EARLY:  return (k >= 0 && k <= 1) || k >= 6;
            CV_LATE:   return k >= 10;
            default:   return 1'b0;
        endcase
    endfunction

    // Cycles from the last input handshake to the first out_valid
    function automatic int model_lat(input int mode);
        for (int k = int'(CORE_LAT) - 1; k < int'(TIMEOUT) - 1; k++) begin
            if (cv_fn(mode, k)) return k + 2;
        end
        return int'(TIMEOUT) + 1;
    endfunction

    task automatic chk(input string nm, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, ".in_ready"},    TILE_W'(in_ready),    TILE_W'(1));
        chk({nm, ".out_valid"},   TILE_W'(out_valid),   '0);
        chk({nm, ".out_last"},    TILE_W'(out_last),    '0);
        chk({nm, ".out_data"},    TILE_W'(out_data),    '0);
        chk({nm, ".core_in"},     core_in,              '0);
        chk({nm, ".busy"},        TILE_W'(busy),        '0);
        chk({nm, ".err_timeout"}, TILE_W'(err_timeout), '0);
`ifdef IDWT_TILE_CTRL_STATS_EN
        chk({nm, ".tile_count"},    TILE_W'(tile_count),    '0);
        chk({nm, ".timeout_count"}, TILE_W'(timeout_count), '0);
`endif
    endtask

    // Assert reset asynchronously between clock edges
    task automatic do_reset(input string nm);
        #2;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        core_valid = 1'b0;
        #1;
        check_reset(nm);
        err_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One tile through the DUT; optionally abandon after abort_in inputs or abort_out outputs
    task automatic run_tile(input tcase_t tc, input int abort_in, input int abort_out, output int rows_out);
        logic [ROW_W-1:0]  tile [ROWS];
        logic [TILE_W-1:0] flat;
        logic [TILE_W-1:0] exp;
        int loaded = 0;
        int ocount = 0;
        int h      = -1;
        int v      = -1;
        int budget = 0;
        int lat;
        bit iv, ordy, exp_ov;

        flat = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            tile[r] = tc.seq_data ? ROW_W'(r) : {$urandom, $urandom};
            flat[r * int'(ROW_W) +: ROW_W] = tile[r];
        end
        exp = core_fn(flat);
        lat = model_lat(tc.cv_mode);

        forever begin
            @(negedge clk);
            cyc++;
            budget++;
            if (abort_in > 0 && loaded >= abort_in) break;
            if (abort_out > 0 && ocount >= abort_out) break;
            if (budget > 300) begin
                total++;
                bad++;
                $display("FAIL tile_budget act=%0d rows exp=%0d rows", ocount, ROWS);
                break;
            end

            exp_ov = (h >= 0) && (cyc >= h + lat) && (ocount < int'(ROWS));
            if (h >= 0 && cyc == h + lat && tc.cv_mode == CV_NEVER) err_m = 1'b1;

            chk("in_ready",    TILE_W'(in_ready),    TILE_W'(loaded < int'(ROWS)));
            chk("out_valid",   TILE_W'(out_valid),   TILE_W'(exp_ov));
            chk("busy",        TILE_W'(busy),        TILE_W'(loaded > 0));
            chk("err_timeout", TILE_W'(err_timeout), TILE_W'(err_m));
            if (out_valid && v < 0 && h >= 0) begin
                v = cyc;
                chk("latency", TILE_W'(v - h), TILE_W'(tc.exp_lat));
            end
            if (exp_ov) begin
                chk("out_data", TILE_W'(out_data), TILE_W'(exp[ocount * int'(ROW_W) +: ROW_W]));
                chk("out_last", TILE_W'(out_last), TILE_W'(ocount == int'(ROWS) - 1));
            end
            if (h >= 0 && cyc == h + 1) chk("core_in", core_in, flat);

            iv         = (loaded < int'(ROWS)) ? ($urandom_range(99) >= tc.gap_pct) : tc.b2b;
            in_valid   = iv;
            in_data    = (loaded < int'(ROWS)) ? tile[loaded] : {$urandom, $urandom};
            ordy       = $urandom_range(99) >= tc.stall_pct;
            out_ready  = ordy;
            core_valid = (h >= 0) ? cv_fn(tc.cv_mode, cyc - h - 1) : (tc.cv_mode == CV_ALWAYS);

            if (iv && in_ready && loaded < int'(ROWS)) begin
                loaded++;
                if (loaded == int'(ROWS)) h = cyc;
            end
            if (out_valid && ordy && ocount < int'(ROWS)) begin
                ocount++;
                if (ocount == int'(ROWS)) break;
            end
        end
        rows_out = ocount;
    endtask

    tcase_t cases [7];
    tcase_t b2b_case;
    int     n;
    int     rows;

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        core_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset("por");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //            gap stall cv_mode    seq b2b lat err
        cases[0] = '{ 0,  0,  CV_ALWAYS, 1'b1, 1'b0, 5,  1'b0};
        cases[1] = '{40, 40,  CV_ALWAYS, 1'b0, 1'b0, 5,  1'b0};
        cases[2] = '{30, 30,  CV_ALWAYS, 1'b0, 1'b0, 5,  1'b0};
        cases[3] = '{ 0, 20,  CV_EARLY,  1'b0, 1'b0, 8,  1'b0};
        cases[4] = '{20,  0,  CV_LATE,   1'b0, 1'b0, 12, 1'b0};
        cases[5] = '{ 0,  0,  CV_NEVER,  1'b0, 1'b0, 33, 1'b1};
        cases[6] = '{30, 30,  CV_ALWAYS, 1'b0, 1'b0, 5,  1'b1};
        b2b_case = '{ 0,  0,  CV_ALWAYS, 1'b0, 1'b1, 5,  1'b0};

        for (int i = 0; i < 7; i++) begin
            run_tile(cases[i], 0, 0, n);
            chk("tile_rows", TILE_W'(n), TILE_W'(ROWS));
            chk("tile_err",  TILE_W'(err_timeout), TILE_W'(cases[i].exp_err));
`ifdef IDWT_TILE_CTRL_STATS_EN
            if (i == 5) chk("timeout_count", TILE_W'(timeout_count), TILE_W'(1));
`endif
        end

        // Reset in the middle of loading, then a clean tile
        run_tile(cases[1], 5, 0, n);
        do_reset("rst_mid_load");
        run_tile(cases[0], 0, 0, n);
        chk("after_load_rst_rows", TILE_W'(n), TILE_W'(ROWS));

        // Reset in the middle of draining, then three back-to-back tiles
        run_tile(cases[2], 0, 3, n);
        do_reset("rst_mid_drain");
        rows = 0;
        for (int t = 0; t < 3; t++) begin
            run_tile(b2b_case, 0, 0, n);
            rows += n;
        end
        chk("b2b_rows", TILE_W'(rows), TILE_W'(24));
`ifdef IDWT_TILE_CTRL_STATS_EN
        chk("tile_count", TILE_W'(tile_count), TILE_W'(3));
        chk("timeout_count_clr", TILE_W'(timeout_count), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
